// File: rtl/seg7_pkg.sv
// Shared seven-segment encodings (active-low, gfedcba) and scan-capture helpers,
// used by both the digit driver and the receive-side capture.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIBBLE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_t;

  // Select buses are at most 8 wide; narrower ones are zero-extended by the caller.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low seven-segment pattern back to a digit,
// flagging the all-off pattern as blank and anything unrecognised as an error.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  always_comb begin
    value = NIBBLE_BLANK;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a scanned seven-segment bus, waits for each (pattern, select) pair to be
// stable for STABLE_CYCLES samples, then decodes and stores it per digit position.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int DIGITS        = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   digit_value,
  output logic [DIGITS-1:0]     digit_blank,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  upd_valid,
  output logic [IDX_W-1:0]      upd_index,
  output logic [3:0]            upd_value,
  output logic                  upd_err
);

  logic [6:0]        s_seg;
  logic [DIGITS-1:0] s_sel;
  cap_state_t        state;
  logic [7:0]        cnt;

  logic [7:0]        sel_ext;
  logic              in_onehot;
  logic              same;
  logic              capture;
  logic [7:0]        cnt_inc;
  logic [IDX_W-1:0]  cap_idx;
  logic [3:0]        dec_value;
  logic              dec_blank;
  logic              dec_err;

  function automatic logic [IDX_W-1:0] sel_index(input logic [DIGITS-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  always_comb begin
    sel_ext              = 8'd0;
    sel_ext[DIGITS-1:0]  = dig_sel;
  end

  // The incoming sample is compared against the registered one, so the counter
  // already reads 1 after the first edge that samples a new one-hot pattern.
  assign in_onehot = is_onehot(sel_ext);
  assign same      = (seg_in == s_seg) && (dig_sel == s_sel);
  assign capture   = (state == SETTLE) && (cnt >= 8'(STABLE_CYCLES));
  assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign cap_idx   = sel_index(s_sel);

  seg7_pattern_decode u_decode (
    .seg   (s_seg),
    .value (dec_value),
    .blank (dec_blank),
    .err   (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg       <= SEG_BLANK;
      s_sel       <= '0;
      state       <= IDLE;
      cnt         <= 8'd0;
      digit_value <= {DIGITS{NIBBLE_BLANK}};
      digit_blank <= '1;
      digit_err   <= '0;
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_value   <= NIBBLE_BLANK;
      upd_err     <= 1'b0;
    end else begin
      s_seg     <= seg_in;
      s_sel     <= dig_sel;
      upd_valid <= 1'b0;

      // Capture always uses the stable registered sample, whatever arrives now.
      if (capture) begin
        digit_value[4*int'(cap_idx) +: 4] <= dec_value;
        digit_blank[cap_idx]              <= dec_blank;
        digit_err[cap_idx]                <= dec_err;
        upd_valid                         <= 1'b1;
        upd_index                         <= cap_idx;
        upd_value                         <= dec_value;
        upd_err                           <= dec_err;
      end

      if (!in_onehot) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
            cnt   <= 8'd1;
          end
          SETTLE: begin
            if (!same) begin
              cnt <= 8'd1;
            end else begin
              cnt <= cnt_inc;
              if (capture) state <= HOLD;
            end
          end
          HOLD: begin
            if (!same) begin
              state <= SETTLE;
              cnt   <= 8'd1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_scan_capture;

  localparam int DIGITS = 4;
  localparam int SC     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] digit_value;
  logic [3:0]  digit_blank;
  logic [3:0]  digit_err;
  logic        upd_valid;
  logic [1:0]  upd_index;
  logic [3:0]  upd_value;
  logic        upd_err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pulses = 0;
  int pulse_edge = 0;
  logic [1:0] p_idx [4];
  logic [3:0] p_val [4];
  logic       p_err [4];

  seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .digit_value (digit_value),
    .digit_blank (digit_blank),
    .digit_err   (digit_err),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .upd_value   (upd_value),
    .upd_err     (upd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and log any update pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (upd_valid) begin
      if (pulses < 4) begin
        p_idx[pulses] = upd_index;
        p_val[pulses] = upd_value;
        p_err[pulses] = upd_err;
      end
      pulses++;
      pulse_edge = edge_n;
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg_in  = s;
    dig_sel = d;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int k;
    rst     = 1'b1;
    seg_in  = 7'($urandom);
    dig_sel = 4'($urandom);
    tick();
    tick();
    check("rst_digit_value", 32'(digit_value), 32'hFFFF);
    check("rst_digit_blank", 32'(digit_blank), 32'hF);
    check("rst_digit_err",   32'(digit_err),   32'h0);
    check("rst_upd_valid",   32'(upd_valid),   32'h0);
    check("rst_upd_index",   32'(upd_index),   32'h0);
    check("rst_upd_value",   32'(upd_value),   32'hF);
    check("rst_upd_err",     32'(upd_err),     32'h0);
    seg_in  = 7'b1111111;
    dig_sel = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Steady capture of a 2 on digit 1
    pulses = 0;
    k = edge_n + 1;
    hold(7'b0100100, 4'b0010, 10);
    check("steady_pulses", 32'(pulses), 32'd1);
    check("steady_edge",   32'(pulse_edge), 32'(k + SC));
    check("steady_idx",    32'(p_idx[0]), 32'd1);
    check("steady_val",    32'(p_val[0]), 32'd2);
    check("steady_err",    32'(p_err[0]), 32'd0);
    check("steady_digit",  32'(digit_value), 32'hFF2F);
    check("steady_blank",  32'(digit_blank), 32'b1101);

    // Scan all four positions: 4, 9, blank, invalid
    pulses = 0;
    hold(7'b0011001, 4'b0001, 6);
    hold(7'b0010000, 4'b0010, 6);
    hold(7'b1111111, 4'b0100, 6);
    hold(7'b0110011, 4'b1000, 6);
    check("scan_pulses", 32'(pulses), 32'd4);
    check("scan_val0", 32'({p_idx[0], p_val[0], p_err[0]}), 32'({2'd0, 4'h4, 1'b0}));
    check("scan_val1", 32'({p_idx[1], p_val[1], p_err[1]}), 32'({2'd1, 4'h9, 1'b0}));
    check("scan_val2", 32'({p_idx[2], p_val[2], p_err[2]}), 32'({2'd2, 4'hF, 1'b0}));
    check("scan_val3", 32'({p_idx[3], p_val[3], p_err[3]}), 32'({2'd3, 4'hF, 1'b1}));
    check("scan_digit", 32'(digit_value), 32'hFF94);
    check("scan_blank", 32'(digit_blank), 32'b0100);
    check("scan_err",   32'(digit_err),   32'b1000);

    // Glitch rejection: only the final stable 8 is captured
    pulses = 0;
    hold(7'b0000000, 4'b0001, 3);
    hold(7'b0000001, 4'b0001, 1);
    check("glitch_early", 32'(pulses), 32'd0);
    k = edge_n + 1;
    hold(7'b0000000, 4'b0001, 8);
    check("glitch_pulses", 32'(pulses), 32'd1);
    check("glitch_edge",   32'(pulse_edge), 32'(k + SC));
    check("glitch_val",    32'(p_val[0]), 32'd8);
    check("glitch_idx",    32'(p_idx[0]), 32'd0);
    check("glitch_digit",  32'(digit_value), 32'hFF98);

    // Invalid select never captures
    pulses = 0;
    hold(7'b0100100, 4'b0011, 20);
    hold(7'b0100100, 4'b0000, 20);
    check("badsel_pulses", 32'(pulses), 32'd0);
    check("badsel_digit",  32'(digit_value), 32'hFF98);
    check("badsel_blank",  32'(digit_blank), 32'b0100);
    check("badsel_err",    32'(digit_err),   32'b1000);

    // Reset with counter at 3 discards partial stability
    pulses = 0;
    hold(7'b1111000, 4'b0100, 3);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(upd_valid), 32'd0);
    check("midrst_digit", 32'(digit_value), 32'hFFFF);
    check("midrst_blank", 32'(digit_blank), 32'hF);
    rst = 1'b0;
    k = edge_n + 1;
    for (int i = 0; i < 8; i++) tick();
    check("midrst_pulses", 32'(pulses), 32'd1);
    check("midrst_edge",   32'(pulse_edge), 32'(k + SC));
    check("midrst_val",    32'(p_val[0]), 32'd7);
    check("midrst_idx",    32'(p_idx[0]), 32'd2);
    check("midrst_digitv", 32'(digit_value), 32'hF7FF);
    check("midrst_blankv", 32'(digit_blank), 32'b1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
